wb_unified_mem_arbiter: RTL and testbench
=========================================

Name: wb_unified_mem_arbiter

Overview:
Two-master to one-slave Wishbone classic arbiter. It lets the core instruction bus (read-only) and data bus (read/write) share a single unified-memory slave port, which allows self-modifying code and FENCE.I on one memory array. Sits between custom_riscv_core and the unified memory / tohost logic. Provides round-robin fairness, one-transfer-per-grant sequencing and a no-ack bus timeout.

Parameters:
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TIMEOUT, 255, cycles a granted transfer may wait for ack/err before the arbiter aborts it; legal range 1..65535

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
i_adr_i  in  AW  instruction bus address
i_cyc_i  in  1  instruction bus cycle
i_stb_i  in  1  instruction bus strobe
i_dat_o  out  DW  instruction read data
i_ack_o  out  1  instruction ack
i_err_o  out  1  instruction error
d_adr_i  in  AW  data bus address
d_dat_i  in  DW  data bus write data
d_we_i  in  1  data write enable
d_sel_i  in  DW/8  data byte selects
d_cyc_i  in  1  data bus cycle
d_stb_i  in  1  data bus strobe
d_dat_o  out  DW  data bus read data
d_ack_o  out  1  data ack
d_err_o  out  1  data error
m_adr_o  out  AW  slave address
m_dat_o  out  DW  slave write data
m_we_o  out  1  slave write enable
m_sel_o  out  DW/8  slave byte selects
m_cyc_o  out  1  slave cycle
m_stb_o  out  1  slave strobe
m_dat_i  in  DW  slave read data
m_ack_i  in  1  slave ack
m_err_i  in  1  slave error
gnt_o  out  2  current grant, one-hot {D,I}; 2'b00 when idle

Behaviour:
- Reset (rst_n, asynchronous, active-low; clock clk): state=IDLE, gnt_o=0, last_gnt=I, holdoff mask=0, timeout counter=0. m_cyc_o, m_stb_o, m_we_o, ack and err outputs are 0. m_adr_o, m_dat_o, m_sel_o are 0.
- Request: req_I = i_cyc_i&i_stb_i, req_D = d_cyc_i&d_stb_i. A master is eligible when it requests and its holdoff bit is clear.
- FSM states: IDLE, GNT_I, GNT_D. The grant is registered, so there is one cycle of arbitration latency from request to m_stb_o.
- IDLE: if only one master is eligible, go to that master's grant state. If both are eligible, grant the master that is not last_gnt; after reset this means D wins the first tie. If none is eligible, stay in IDLE.
- GNT_x: m_cyc_o/m_stb_o/m_adr_o are muxed combinationally from master x.
  - For I: m_we_o=0, m_sel_o=all ones, m_dat_o=0.
  - For D: we, sel and dat pass through.
  - m_dat_i drives both i_dat_o and d_dat_o. Ack and err go only to the granted master; the other master sees 0.
- Completion: on m_ack_i or m_err_i, the response goes combinationally to the master in the same cycle. Next state is IDLE, last_gnt<=x, and holdoff[x]<=1 for exactly one cycle. The holdoff masks the stale strobe the core holds for one cycle after ack.
- If m_ack_i and m_err_i are asserted in the same cycle, err wins and ack to the master is suppressed.
- Abort: if the granted master drops cyc before ack, go to IDLE next cycle. No response is given, last_gnt is updated and holdoff is not set.
- Timeout: the counter increments each GNT cycle without ack/err. When the count reaches TIMEOUT:
  - assert err to the granted master for one cycle;
  - force m_cyc_o/m_stb_o low that cycle;
  - go to IDLE with holdoff set.
  The counter clears on every grant entry.
- Ack/err arriving from the slave while in IDLE is ignored.
- Reset mid-grant: all outputs drop asynchronously to their reset values.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum {IDLE, GNT_I, GNT_D};
  - grant one-hot constants GNT_NONE=2'b00, GNT_I=2'b01, GNT_D=2'b10;
  - the I-bus fixed select constant (all ones).
- One natural sub-module, wb_timeout_ctr: clear/enable inputs and an expired output, parameterised by TIMEOUT.

Test Plan:
- Fetch only: i_stb at adr 0x100, slave acks 1 cycle after stb -> m_stb_o one cycle after request; i_ack_o asserted with slave data 0x00000013; gnt_o=01 then 00; no re-grant on the stale stb cycle.
- Data halfword write: d_adr 0x1000, d_dat 0x0000BEEF, sel 4'b0011 -> m_sel_o=0011 and m_we_o=1; only d_ack_o pulses; i_ack_o stays 0.
- Tie from reset: both request in the same cycle -> D granted first, I granted at the next IDLE; same tie again -> D again (last_gnt=I).
- Fairness: D re-requests continuously while I is pending -> grants alternate D,I,D,I; neither master waits more than one transfer.
- Timeout with TIMEOUT=8, slave never acks -> err on the granted master exactly 8 cycles after grant, m_cyc_o low that cycle, then IDLE; ack+err together -> err only.
- Reset asserted during GNT_D -> m_cyc_o=0 and gnt_o=0 immediately; after release the first tie goes to D.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the unified-memory Wishbone arbiter.
// Holds the FSM state enum, one-hot grant codes and the I-bus select.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    // Fetches are always full-word; sliced to DW/8 by the user.
    localparam logic [127:0] I_SEL_ALL = '1;

endpackage

// File: rtl/wb_timeout_ctr.sv
// No-ack watchdog for a granted Wishbone transfer.
// Ports: clk, rst_n, clr (zero count), en (count), expired (count == TIMEOUT).
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] cnt;

    assign expired = (cnt == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wb_unified_mem_arbiter.sv
// Two-master (I fetch, D load/store) to one-slave Wishbone classic arbiter.
// Ports: i_* fetch master, d_* data master, m_* slave side, gnt_o {D,I}.
module wb_unified_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   i_adr_i,
    input  logic            i_cyc_i,
    input  logic            i_stb_i,
    output logic [DW-1:0]   i_dat_o,
    output logic            i_ack_o,
    output logic            i_err_o,
    input  logic [AW-1:0]   d_adr_i,
    input  logic [DW-1:0]   d_dat_i,
    input  logic            d_we_i,
    input  logic [DW/8-1:0] d_sel_i,
    input  logic            d_cyc_i,
    input  logic            d_stb_i,
    output logic [DW-1:0]   d_dat_o,
    output logic            d_ack_o,
    output logic            d_err_o,
    output logic [AW-1:0]   m_adr_o,
    output logic [DW-1:0]   m_dat_o,
    output logic            m_we_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    input  logic [DW-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_err_i,
    output logic [1:0]      gnt_o
);

    localparam int SW = DW / 8;

    state_t     state;
    state_t     state_nxt;
    logic       last_d;
    logic       last_d_nxt;
    logic [1:0] holdoff;
    logic [1:0] holdoff_nxt;
    logic       expired;
    logic       elig_i;
    logic       elig_d;
    logic       done;
    logic       resp_ack;
    logic       resp_err;

    // Holdoff masks the strobe a master still shows the cycle after ack.
    assign elig_i = i_cyc_i & i_stb_i & ~holdoff[0];
    assign elig_d = d_cyc_i & d_stb_i & ~holdoff[1];

    // Watchdog expiry wins over any slave response, and err beats ack.
    assign done     = m_ack_i | m_err_i | expired;
    assign resp_err = m_err_i | expired;
    assign resp_ack = m_ack_i & ~m_err_i & ~expired;

    assign i_dat_o = m_dat_i;
    assign d_dat_o = m_dat_i;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == S_IDLE),
        .en      ((state != S_IDLE) & ~m_ack_i & ~m_err_i),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            last_d  <= 1'b0;
            holdoff <= GNT_NONE;
        end else begin
            state   <= state_nxt;
            last_d  <= last_d_nxt;
            holdoff <= holdoff_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_d_nxt  = last_d;
        holdoff_nxt = GNT_NONE;
        gnt_o       = GNT_NONE;
        m_adr_o     = '0;
        m_dat_o     = '0;
        m_we_o      = 1'b0;
        m_sel_o     = '0;
        m_cyc_o     = 1'b0;
        m_stb_o     = 1'b0;
        i_ack_o     = 1'b0;
        i_err_o     = 1'b0;
        d_ack_o     = 1'b0;
        d_err_o     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (elig_i && elig_d) begin
                    state_nxt = last_d ? S_GNT_I : S_GNT_D;
                end else if (elig_d) begin
                    state_nxt = S_GNT_D;
                end else if (elig_i) begin
                    state_nxt = S_GNT_I;
                end
            end
            S_GNT_I: begin
                gnt_o   = GNT_I;
                m_adr_o = i_adr_i;
                m_sel_o = I_SEL_ALL[SW-1:0];
                m_cyc_o = i_cyc_i & ~expired;
                m_stb_o = i_stb_i & ~expired;
                if (!i_cyc_i) begin
                    state_nxt  = S_IDLE;
                    last_d_nxt = 1'b0;
                end else if (done) begin
                    i_ack_o     = resp_ack;
                    i_err_o     = resp_err;
                    state_nxt   = S_IDLE;
                    last_d_nxt  = 1'b0;
                    holdoff_nxt = GNT_I;
                end
            end
            S_GNT_D: begin
                gnt_o   = GNT_D;
                m_adr_o = d_adr_i;
                m_dat_o = d_dat_i;
                m_we_o  = d_we_i;
                m_sel_o = d_sel_i;
                m_cyc_o = d_cyc_i & ~expired;
                m_stb_o = d_stb_i & ~expired;
                if (!d_cyc_i) begin
                    state_nxt  = S_IDLE;
                    last_d_nxt = 1'b1;
                end else if (done) begin
                    d_ack_o     = resp_ack;
                    d_err_o     = resp_err;
                    state_nxt   = S_IDLE;
                    last_d_nxt  = 1'b1;
                    holdoff_nxt = GNT_D;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed bench for wb_unified_mem_arbiter with TIMEOUT=8.
// Vector table for single transfers plus hand sequences for corners.
module tb_wb_unified_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_adr_i;
    logic        i_cyc_i;
    logic        i_stb_i;
    logic [31:0] i_dat_o;
    logic        i_ack_o;
    logic        i_err_o;
    logic [31:0] d_adr_i;
    logic [31:0] d_dat_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic        d_cyc_i;
    logic        d_stb_i;
    logic [31:0] d_dat_o;
    logic        d_ack_o;
    logic        d_err_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;
    logic        m_err_i;
    logic [1:0]  gnt_o;

    always #5 clk = ~clk;

    wb_unified_mem_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_adr_i (i_adr_i),
        .i_cyc_i (i_cyc_i),
        .i_stb_i (i_stb_i),
        .i_dat_o (i_dat_o),
        .i_ack_o (i_ack_o),
        .i_err_o (i_err_o),
        .d_adr_i (d_adr_i),
        .d_dat_i (d_dat_i),
        .d_we_i  (d_we_i),
        .d_sel_i (d_sel_i),
        .d_cyc_i (d_cyc_i),
        .d_stb_i (d_stb_i),
        .d_dat_o (d_dat_o),
        .d_ack_o (d_ack_o),
        .d_err_o (d_err_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_we_o  (m_we_o),
        .m_sel_o (m_sel_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_dat_i (m_dat_i),
        .m_ack_i (m_ack_i),
        .m_err_i (m_err_i),
        .gnt_o   (gnt_o)
    );

    typedef struct {
        logic        is_d;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] rdat;
        logic        ack;
        logic        err;
        logic [1:0]  e_gnt;
        logic [3:0]  e_sel;
        logic        e_we;
        logic [31:0] e_mdat;
        logic        e_iack;
        logic        e_ierr;
        logic        e_dack;
        logic        e_derr;
    } vec_t;

    vec_t vecs[6];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        i_cyc_i = 1'b0;
        i_stb_i = 1'b0;
        d_cyc_i = 1'b0;
        d_stb_i = 1'b0;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
    endtask

    task automatic wait_gnt(input logic [1:0] g, input string nm);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (gnt_o == g) break;
        end
        chk(nm, 32'(gnt_o), 32'(g));
    endtask

    task automatic run_vec(input vec_t v);
        d_dat_i = v.wdat;
        d_we_i  = v.we;
        d_sel_i = v.sel;
        m_dat_i = v.rdat;
        if (v.is_d) begin
            d_adr_i = v.adr;
            d_cyc_i = 1'b1;
            d_stb_i = 1'b1;
        end else begin
            i_adr_i = v.adr;
            i_cyc_i = 1'b1;
            i_stb_i = 1'b1;
        end
        @(negedge clk);
        chk("lat_stb", 32'(m_stb_o), 32'(0));
        chk("lat_gnt", 32'(gnt_o), 32'(0));
        step();
        @(negedge clk);
        chk("gnt", 32'(gnt_o), 32'(v.e_gnt));
        chk("m_cyc", 32'(m_cyc_o), 32'(1));
        chk("m_stb", 32'(m_stb_o), 32'(1));
        chk("m_adr", m_adr_o, v.adr);
        chk("m_sel", 32'(m_sel_o), 32'(v.e_sel));
        chk("m_we", 32'(m_we_o), 32'(v.e_we));
        chk("m_dat", m_dat_o, v.e_mdat);
        chk("early_ack", 32'({i_ack_o, d_ack_o}), 32'(0));
        step();
        m_ack_i = v.ack;
        m_err_i = v.err;
        @(negedge clk);
        chk("i_ack", 32'(i_ack_o), 32'(v.e_iack));
        chk("i_err", 32'(i_err_o), 32'(v.e_ierr));
        chk("d_ack", 32'(d_ack_o), 32'(v.e_dack));
        chk("d_err", 32'(d_err_o), 32'(v.e_derr));
        chk("rdat", v.is_d ? d_dat_o : i_dat_o, v.rdat);
        step();
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        @(negedge clk);
        chk("stale_gnt", 32'(gnt_o), 32'(0));
        chk("stale_stb", 32'(m_stb_o), 32'(0));
        step();
        idle_bus();
        step();
    endtask

    logic [1:0] seq[4];
    logic [1:0] fexp[4];
    int         ng;

    initial begin
        vecs[0] = '{is_d:1'b0, adr:32'h100, wdat:32'hDEADBEEF,
                    we:1'b1, sel:4'b0101, rdat:32'h13,
                    ack:1'b1, err:1'b0, e_gnt:2'b01,
                    e_sel:4'hF, e_we:1'b0, e_mdat:32'h0,
                    e_iack:1'b1, e_ierr:1'b0,
                    e_dack:1'b0, e_derr:1'b0};
        vecs[1] = '{is_d:1'b1, adr:32'h1000, wdat:32'hBEEF,
                    we:1'b1, sel:4'b0011, rdat:32'h0,
                    ack:1'b1, err:1'b0, e_gnt:2'b10,
                    e_sel:4'b0011, e_we:1'b1, e_mdat:32'hBEEF,
                    e_iack:1'b0, e_ierr:1'b0,
                    e_dack:1'b1, e_derr:1'b0};
        vecs[2] = '{is_d:1'b1, adr:32'h2000, wdat:32'h0,
                    we:1'b0, sel:4'hF, rdat:32'hCAFEBABE,
                    ack:1'b1, err:1'b0, e_gnt:2'b10,
                    e_sel:4'hF, e_we:1'b0, e_mdat:32'h0,
                    e_iack:1'b0, e_ierr:1'b0,
                    e_dack:1'b1, e_derr:1'b0};
        vecs[3] = '{is_d:1'b0, adr:32'h104, wdat:32'h11,
                    we:1'b0, sel:4'h0, rdat:32'h12345678,
                    ack:1'b0, err:1'b1, e_gnt:2'b01,
                    e_sel:4'hF, e_we:1'b0, e_mdat:32'h0,
                    e_iack:1'b0, e_ierr:1'b1,
                    e_dack:1'b0, e_derr:1'b0};
        vecs[4] = '{is_d:1'b1, adr:32'h3000, wdat:32'h55AA,
                    we:1'b1, sel:4'b1100, rdat:32'h0,
                    ack:1'b1, err:1'b1, e_gnt:2'b10,
                    e_sel:4'b1100, e_we:1'b1, e_mdat:32'h55AA,
                    e_iack:1'b0, e_ierr:1'b0,
                    e_dack:1'b0, e_derr:1'b1};
        vecs[5] = '{is_d:1'b0, adr:32'h108, wdat:32'h0,
                    we:1'b0, sel:4'h0, rdat:32'h9,
                    ack:1'b1, err:1'b1, e_gnt:2'b01,
                    e_sel:4'hF, e_we:1'b0, e_mdat:32'h0,
                    e_iack:1'b0, e_ierr:1'b1,
                    e_dack:1'b0, e_derr:1'b0};
        fexp[0] = 2'b10;
        fexp[1] = 2'b01;
        fexp[2] = 2'b10;
        fexp[3] = 2'b01;

        // Reset with a live D request and slave ack: all quiet.
        rst_n   = 1'b0;
        i_adr_i = '0;
        d_adr_i = 32'h77;
        d_dat_i = 32'h1234;
        d_we_i  = 1'b1;
        d_sel_i = 4'hF;
        m_dat_i = '0;
        idle_bus();
        d_cyc_i = 1'b1;
        d_stb_i = 1'b1;
        m_ack_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(m_cyc_o), 32'(0));
        chk("rst_stb", 32'(m_stb_o), 32'(0));
        chk("rst_gnt", 32'(gnt_o), 32'(0));
        chk("rst_adr", m_adr_o, 32'h0);
        chk("rst_mdat", m_dat_o, 32'h0);
        chk("rst_sel", 32'(m_sel_o), 32'(0));
        chk("rst_we", 32'(m_we_o), 32'(0));
        chk("rst_dack", 32'(d_ack_o), 32'(0));
        idle_bus();
        step();
        rst_n = 1'b1;
        step();

        // Stray slave ack while idle goes nowhere.
        m_ack_i = 1'b1;
        m_err_i = 1'b1;
        @(negedge clk);
        chk("idle_ack", 32'({i_ack_o, i_err_o, d_ack_o, d_err_o}), 32'(0));
        step();
        idle_bus();
        step();

        // Tie from reset: D first, then I.
        i_adr_i = 32'h200;
        d_adr_i = 32'h300;
        d_we_i  = 1'b0;
        i_cyc_i = 1'b1;
        i_stb_i = 1'b1;
        d_cyc_i = 1'b1;
        d_stb_i = 1'b1;
        @(negedge clk);
        chk("tie_lat", 32'(gnt_o), 32'(0));
        step();
        @(negedge clk);
        chk("tie1_d", 32'(gnt_o), 32'(2'b10));
        chk("tie1_adr", m_adr_o, 32'h300);
        step();
        m_ack_i = 1'b1;
        @(negedge clk);
        chk("tie1_dack", 32'({i_ack_o, d_ack_o}), 32'(2'b01));
        step();
        m_ack_i = 1'b0;
        @(negedge clk);
        chk("tie1_hold", 32'(gnt_o), 32'(0));
        step();
        d_cyc_i = 1'b0;
        d_stb_i = 1'b0;
        @(negedge clk);
        chk("tie1_i", 32'(gnt_o), 32'(2'b01));
        step();
        m_ack_i = 1'b1;
        @(negedge clk);
        chk("tie1_iack", 32'({i_ack_o, d_ack_o}), 32'(2'b10));
        step();
        idle_bus();
        step();
        step();
        i_cyc_i = 1'b1;
        i_stb_i = 1'b1;
        d_cyc_i = 1'b1;
        d_stb_i = 1'b1;
        step();
        @(negedge clk);
        chk("tie2_d", 32'(gnt_o), 32'(2'b10));
        step();
        m_ack_i = 1'b1;
        step();
        idle_bus();
        step();

        foreach (vecs[k]) run_vec(vecs[k]);

        // Fairness: both masters request back to back.
        foreach (seq[k]) seq[k] = 2'b00;
        ng = 0;
        i_adr_i = 32'h400;
        d_adr_i = 32'h4000;
        i_cyc_i = 1'b1;
        i_stb_i = 1'b1;
        d_cyc_i = 1'b1;
        d_stb_i = 1'b1;
        for (int n = 0; n < 40 && ng < 4; n++) begin
            step();
            m_ack_i = m_stb_o;
            @(negedge clk);
            if (gnt_o != 2'b00) begin
                seq[ng] = gnt_o;
                ng++;
            end
        end
        chk("fair_cnt", 32'(ng), 32'(4));
        foreach (seq[k]) chk("fair_seq", 32'(seq[k]), 32'(fexp[k]));
        step();
        idle_bus();
        step();
        step();

        // Watchdog: slave never answers an I fetch.
        i_adr_i = 32'h500;
        i_cyc_i = 1'b1;
        i_stb_i = 1'b1;
        wait_gnt(2'b01, "tmo_gnt");
        for (int k = 0; k <= TO; k++) begin
            if (k > 0) begin
                step();
                @(negedge clk);
            end
            chk("tmo_err", 32'(i_err_o), 32'(k == TO));
            chk("tmo_cyc", 32'(m_cyc_o), 32'(k != TO));
        end
        chk("tmo_dclean", 32'({d_ack_o, d_err_o}), 32'(0));
        step();
        @(negedge clk);
        chk("tmo_idle", 32'(gnt_o), 32'(0));
        chk("tmo_err_once", 32'(i_err_o), 32'(0));
        step();
        idle_bus();
        step();
        step();

        // Reset in the middle of a D grant.
        d_adr_i = 32'h600;
        d_cyc_i = 1'b1;
        d_stb_i = 1'b1;
        wait_gnt(2'b10, "mid_gnt");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(m_cyc_o), 32'(0));
        chk("mid_rst_gnt", 32'(gnt_o), 32'(0));
        chk("mid_rst_adr", m_adr_o, 32'h0);
        idle_bus();
        step();
        step();
        rst_n = 1'b1;
        step();
        i_cyc_i = 1'b1;
        i_stb_i = 1'b1;
        d_cyc_i = 1'b1;
        d_stb_i = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_tie", 32'(gnt_o), 32'(2'b10));
        step();
        idle_bus();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
